deser_8way: RTL

- Receive-side counterpart of the 8-to-1 select path. A transmitter walks its select lines s2,s1,s0 from 0 to 7 and sends in0..in7 one bit per slot; this block rebuilds the 8 parallel bits.
- It tracks the slot in a 3-bit counter and steers each received bit into the matching storage slot (8-way demux into a register bank).
- When the frame is complete, it presents the 8 bits on out0..out7 with a one-cycle done strobe.
- It sits at the far end of the serial link, feeding lab datapath logic.

---
 rtl/deser_8way.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/deser_8way.sv
// Serial-to-parallel receiver: rebuilds an 8-bit word from a framed bit stream.
// A start bit opens a frame; the 8th accepted bit publishes the word.
module deser_8way #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic din_valid,
    input  logic start,
    output logic out0,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic out4,
    output logic out5,
    output logic out6,
    output logic out7,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic [2:0] idx;
    logic [2:0] slot;
    logic       wr;
    logic       clr_buf;
    logic       ld_out;
    logic       done_nxt;
    logic       err_nxt;
    logic [7:0] wr_en;
    logic [7:0] buf_q;
    logic [7:0] buf_nxt;
    logic [7:0] word_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx       = cnt;
        wr        = 1'b0;
        clr_buf   = 1'b0;
        ld_out    = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (din_valid) begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = RECV;
                        cnt_nxt   = 3'd1;
                        idx       = 3'd0;
                        wr        = 1'b1;
                        clr_buf   = 1'b1;
                    end
                end
                RECV: begin
                    if (start) begin
                        // Restart: the partial frame is dropped
                        cnt_nxt = 3'd1;
                        idx     = 3'd0;
                        wr      = 1'b1;
                        clr_buf = 1'b1;
                        err_nxt = 1'b1;
                    end else begin
                        wr      = 1'b1;
                        cnt_nxt = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            state_nxt = IDLE;
                            ld_out    = 1'b1;
                            done_nxt  = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign slot  = MSB_FIRST ? (3'd7 - idx) : idx;
    assign wr_en = wr ? (8'b1 << slot) : 8'b0;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            if (wr_en[i]) buf_nxt[i] = din;
            else if (clr_buf) buf_nxt[i] = 1'b0;
            else buf_nxt[i] = buf_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q <= 8'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_en[i] || clr_buf) buf_q[i] <= buf_nxt[i];
            end
        end
    end

    // The completing bit goes straight into the output bank with the buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) word_q <= 8'b0;
        else if (ld_out) word_q <= buf_nxt;
    end

    always_comb begin
        busy = (state == RECV);
        s0   = cnt[0];
        s1   = cnt[1];
        s2   = cnt[2];
    end

    assign out0 = word_q[0];
    assign out1 = word_q[1];
    assign out2 = word_q[2];
    assign out3 = word_q[3];
    assign out4 = word_q[4];
    assign out5 = word_q[5];
    assign out6 = word_q[6];
    assign out7 = word_q[7];

endmodule
